// File: rtl/mips_cpu_bus_master.sv
// Bridges single-request MIPS core loads/stores onto a 32-bit waitrequest-style bus.
// Optional macro BUS_WAIT_TIMEOUT_EN aborts a bus cycle stalled for TIMEOUT_CYCLES waits.
module mips_cpu_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] addr,
    output logic [31:0] writedata,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            default: bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{wd[7:0]}};
            2'b01:   lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    // Pull the addressed lane down to bit 0 and extend it to 32 bits.
    function automatic logic [31:0] extract(input logic [1:0] size, input logic sgn,
                                            input logic [1:0] off, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            2'b11:   b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'b00:   res = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
            2'b01:   res = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        is_write_q, is_write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] writedata_q, writedata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

`ifdef BUS_WAIT_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 32'd1);
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        read_d       = read_q;
        write_d      = write_q;
        byteenable_d = byteenable_q;
        addr_d       = addr_q;
        writedata_d  = writedata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
`ifdef BUS_WAIT_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_write_d = req_write;
                    size_d     = req_size;
                    signed_d   = req_signed;
                    off_d      = req_addr[1:0];
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d      = ISSUE;
                        read_d       = ~req_write;
                        write_d      = req_write;
                        byteenable_d = calc_be(req_size, req_addr[1:0]);
                        addr_d       = {req_addr[31:2], 2'b00};
                        writedata_d  = calc_wdata(req_size, req_wdata);
`ifdef BUS_WAIT_TIMEOUT_EN
                        tmo_cnt_d    = '0;
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (is_write_q) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
`ifdef BUS_WAIT_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    // The wait that brings the count to the limit is the last one tolerated.
                    if (32'(tmo_cnt_d) >= TIMEOUT_CYCLES) begin
                        read_d       = 1'b0;
                        write_d      = 1'b0;
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end
            RDATA: begin
                resp_rdata_d = extract(size_q, signed_q, off_q, readdata);
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    // State and registered-output flops; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            is_write_q   <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= 4'b0000;
            addr_q       <= 32'h0000_0000;
            writedata_q  <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
`ifdef BUS_WAIT_TIMEOUT_EN
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            is_write_q   <= is_write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            read_q       <= read_d;
            write_q      <= write_d;
            byteenable_q <= byteenable_d;
            addr_q       <= addr_d;
            writedata_q  <= writedata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
`ifdef BUS_WAIT_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = byteenable_q;
    assign addr       = addr_q;
    assign writedata  = writedata_q;

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Directed bench for mips_cpu_bus_master: loads, stores, misalignment, wait states, reset abort.
module tb_mips_cpu_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        read, write, waitrequest;
    logic [3:0]  byteenable;
    logic [31:0] addr, writedata, readdata;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_rdata;

    mips_cpu_bus_master #(.TIMEOUT_CYCLES(32'd4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .read(read), .write(write), .byteenable(byteenable),
        .addr(addr), .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    // Drop the request and scramble its fields so the DUT must rely on its own copy.
    task automatic withdraw();
        req_valid = 1'b0;
        req_write = ~req_write;
        req_size  = 2'b11;
        req_addr  = 32'hFFFF_FFF3;
        req_wdata = 32'h1234_5678;
    endtask

    initial begin
        int stuck;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        waitrequest = 1'b0; readdata = 32'h0;
        #12;
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_be", 32'(byteenable), 32'd0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // Word load 0x100, zero wait
        present(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        readdata = 32'hDEAD_BEEF;
        chk("ld_ready_idle", 32'(req_ready), 32'd1);
        tick();
        withdraw();
        chk("ld_c1_read", 32'(read), 32'd1);
        chk("ld_c1_write", 32'(write), 32'd0);
        chk("ld_c1_addr", addr, 32'h0000_0100);
        chk("ld_c1_be", 32'(byteenable), 32'hF);
        chk("ld_c1_ready", 32'(req_ready), 32'd0);
        chk("ld_c1_rv", 32'(resp_valid), 32'd0);
        tick();
        chk("ld_c2_read", 32'(read), 32'd0);
        chk("ld_c2_rv", 32'(resp_valid), 32'd0);
        tick();
        readdata = 32'h5555_5555;
        chk("ld_c3_rv", 32'(resp_valid), 32'd1);
        chk("ld_c3_err", 32'(resp_err), 32'd0);
        chk("ld_c3_rdata", resp_rdata, 32'hDEAD_BEEF);
        tick();
        chk("ld_c4_rv", 32'(resp_valid), 32'd0);
        chk("ld_c4_ready", 32'(req_ready), 32'd1);
        chk("ld_c4_rdata_hold", resp_rdata, 32'hDEAD_BEEF);

        // Byte loads at 0x203 (signed, unsigned) and half load at 0x202 (signed)
        for (int k = 0; k < 3; k++) begin
            present(1'b0, (k == 2) ? 2'b01 : 2'b00, (k != 1), (k == 2) ? 32'h202 : 32'h203, 32'h0);
            exp_rdata = (k == 0) ? 32'hFFFF_FF80 : (k == 1) ? 32'h0000_0080 : 32'hFFFF_8011;
            tick();
            withdraw();
            chk("sub_addr", addr, 32'h0000_0200);
            chk("sub_be", 32'(byteenable), (k == 2) ? 32'hC : 32'h8);
            tick();
            readdata = 32'h8011_2233;
            tick();
            readdata = 32'h0;
            chk("sub_rv", 32'(resp_valid), 32'd1);
            chk("sub_rdata", resp_rdata, exp_rdata);
            tick();
        end

        // Half store 0x0A with three wait cycles
        present(1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h0000_ABCD);
        waitrequest = 1'b1;
        tick();
        withdraw();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) waitrequest = 1'b0;
            chk("st_write", 32'(write), 32'd1);
            chk("st_read", 32'(read), 32'd0);
            chk("st_addr", addr, 32'h0000_0008);
            chk("st_be", 32'(byteenable), 32'hC);
            chk("st_wdata", writedata, 32'hABCD_ABCD);
            chk("st_rv_wait", 32'(resp_valid), 32'd0);
            tick();
        end
        chk("st_done_write", 32'(write), 32'd0);
        chk("st_rv", 32'(resp_valid), 32'd1);
        chk("st_err", 32'(resp_err), 32'd0);
        chk("st_rdata_kept", resp_rdata, exp_rdata);
        tick();
        chk("st_rv_once", 32'(resp_valid), 32'd0);

        // Byte store at offset 1, zero wait
        present(1'b1, 2'b00, 1'b0, 32'h0000_0301, 32'h0000_00A5);
        tick();
        withdraw();
        chk("sb_be", 32'(byteenable), 32'h2);
        chk("sb_wdata", writedata, 32'hA5A5_A5A5);
        chk("sb_addr", addr, 32'h0000_0300);
        tick();
        chk("sb_rv", 32'(resp_valid), 32'd1);
        tick();

        // Misaligned word load 0x102
        present(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0);
        tick();
        withdraw();
        chk("mis_read", 32'(read), 32'd0);
        chk("mis_write", 32'(write), 32'd0);
        chk("mis_rv", 32'(resp_valid), 32'd1);
        chk("mis_err", 32'(resp_err), 32'd1);
        chk("mis_rdata_kept", resp_rdata, exp_rdata);
        tick();
        chk("mis_rv_off", 32'(resp_valid), 32'd0);
        chk("mis_ready", 32'(req_ready), 32'd1);

        // Load with waitrequest stuck high
        present(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        waitrequest = 1'b1;
        tick();
        withdraw();
`ifdef BUS_WAIT_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            chk("tmo_read_held", 32'(read), 32'd1);
            tick();
        end
        chk("tmo_read_drop", 32'(read), 32'd0);
        chk("tmo_rv", 32'(resp_valid), 32'd1);
        chk("tmo_err", 32'(resp_err), 32'd1);
        tick();
        present(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        tick();
        withdraw();
        tick();
`else
        stuck = 0;
        for (int c = 0; c < 100; c++) begin
            if (read !== 1'b1 || resp_valid !== 1'b0) stuck++;
            tick();
        end
        chk("nowait_tmo_glitches", 32'(stuck), 32'd0);
        chk("nowait_read_held", 32'(read), 32'd1);
`endif

        // Asynchronous reset during ISSUE
        chk("pre_rst_read", 32'(read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_read", 32'(read), 32'd0);
        chk("arst_addr", addr, 32'h0);
        chk("arst_rv", 32'(resp_valid), 32'd0);
        chk("arst_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        waitrequest = 1'b0;
        tick();
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_no_rv", 32'(resp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus_master.md
MIPS_CPU_BUS_MASTER -- requirements
Module: mips_cpu_bus_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max consecutive waitrequest cycles before abort (used only with REQ-030).
REQ-002 Port: clk  in  1  single clock, all state on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Core side: req_valid in 1 request present; req_ready out 1 request accepted when both high at a rising edge; req_write in 1 store=1/load=0; req_size in 2 00 byte, 01 half, 10 word (11 treated as word); req_signed in 1 sign-extend load; req_addr in 32 byte address; req_wdata in 32 store data, right-aligned.
REQ-005 Core side: resp_valid out 1 one-cycle completion pulse; resp_rdata out 32 extended load data; resp_err out 1 error flag, qualified by resp_valid.
REQ-006 Bus side: read out 1; write out 1; byteenable out 4; addr out 32; writedata out 32; waitrequest in 1; readdata in 32.

Function
REQ-007 FSM states SHALL be IDLE, ISSUE, RDATA, RESP; req_ready SHALL be 1 only in IDLE.
REQ-008 On acceptance, request fields SHALL be registered; later req_* changes SHALL not affect the transaction.
REQ-009 Misaligned request (half with addr[0]=1, word with addr[1:0]!=0) SHALL go IDLE->RESP with resp_err=1, no bus strobe.
REQ-010 Aligned request SHALL go IDLE->ISSUE; in ISSUE exactly one of read/write SHALL be 1.
REQ-011 addr SHALL be {req_addr[31:2],2'b00}.
REQ-012 byteenable: byte at offset k -> 1<<k; half offset 0 -> 0011, offset 2 -> 1100; word -> 1111.
REQ-013 writedata: byte replicated to all four lanes; half replicated to both halves; word unchanged.
REQ-014 All bus outputs SHALL hold stable while waitrequest=1 in ISSUE.
REQ-015 Bus acceptance = rising edge in ISSUE with waitrequest=0; write then ->RESP, read then ->RDATA; read/write SHALL deassert after acceptance.
REQ-016 Readdata SHALL be sampled at the end of the single RDATA cycle (fixed 1-cycle read latency), then ->RESP.
REQ-017 Load extraction: selected lane shifted to bit 0, sign-extended if req_signed else zero-extended; word passes unchanged.
REQ-018 RESP SHALL last exactly one cycle with resp_valid=1, then ->IDLE; resp_rdata SHALL hold until next load completes; resp_err=0 on normal completion.
REQ-019 Zero-wait latency from acceptance edge: store resp_valid in 2nd cycle, load in 3rd, misaligned in 1st.
REQ-020 Store completion SHALL leave resp_rdata unchanged.
REQ-021 waitrequest SHALL be ignored outside ISSUE; readdata ignored outside RDATA.
REQ-022 Back-to-back: request presented in IDLE after RESP SHALL be accepted; minimum 4-cycle spacing for zero-wait loads.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE and read=0, write=0, byteenable=0, addr=0, writedata=0.
REQ-024 rst_n=0 SHALL clear resp_valid, resp_err, resp_rdata to 0; timeout counter to 0.
REQ-025 Reset mid-transaction SHALL abort without a response pulse; first acceptance possible at first rising edge with rst_n=1.

Configuration
REQ-030 With BUS_WAIT_TIMEOUT_EN defined: counter increments each ISSUE cycle with waitrequest=1, clears on entry to ISSUE; on reaching TIMEOUT_CYCLES, read/write SHALL drop next cycle and FSM ->RESP with resp_err=1.
REQ-031 Without BUS_WAIT_TIMEOUT_EN: no counter logic; ISSUE SHALL wait indefinitely on waitrequest.

Verification
REQ-040 Word load 0x100, readdata=0xDEADBEEF, waitrequest=0 -> read=1 addr=0x100 be=1111 one cycle; resp_rdata=0xDEADBEEF, resp_valid 3rd cycle.
REQ-041 Signed byte load 0x203, readdata=0x80112233 -> be=1000, resp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-042 Half store 0x0A, wdata=0x0000ABCD, waitrequest high 3 cycles -> write held 4 cycles, addr=0x08 be=1100 writedata=0xABCDABCD stable; resp_valid once.
REQ-043 Word load 0x102 -> no read/write, resp_valid with resp_err=1 next cycle.
REQ-044 rst_n low during ISSUE with waitrequest=1 -> read=0 immediately, no resp_valid, req_ready=1 after release.
REQ-045 BUS_WAIT_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1 -> read dropped after 4 wait cycles, resp_err=1; without macro, still waiting after 100 cycles.
